// File: rtl/nibble_serial_sub_ctrl_pkg.sv
// ============================================================================
// Module  : nibble_serial_sub_ctrl_pkg
// Brief   : FSM encodings and width-check helper for the nibble-serial subtractor.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package nibble_serial_sub_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int c_NIB_BITS = 4;

  // Legal widths are whole nibbles, at least one nibble.
  function automatic bit nib_width_ok(input int w);
    return (w >= c_NIB_BITS) && ((w % c_NIB_BITS) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/nibble_serial_sub_ctrl_if.sv
// ============================================================================
// Module  : nibble_serial_sub_ctrl_if
// Brief   : Operand (valid/ready) and result (valid/ready) bundle for the subtractor.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface nibble_serial_sub_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             zero;

  // Block-side view
  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout, zero
  );

  // Producer/consumer-side view
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout, zero
  );
endinterface

`default_nettype wire

// File: rtl/nibble_borrow_sub.sv
// ============================================================================
// Module  : nibble_borrow_sub
// Brief   : Combinational 4-bit borrow-propagate subtract slice (d = a - b - bi).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module nibble_borrow_sub (
  input  wire logic [3:0] i_a,
  input  wire logic [3:0] i_b,
  input  wire logic       i_bi,
  output logic      [3:0] o_d,
  output logic            o_bo
);

  logic [4:0] w_br;

  assign w_br[0] = i_bi;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign o_d[i]    = i_a[i] ^ i_b[i] ^ w_br[i];
    assign w_br[i+1] = (~(i_a[i] ^ i_b[i]) & w_br[i]) | (~i_a[i] & i_b[i]);
  end

  assign o_bo = w_br[4];

endmodule

`default_nettype wire

// File: rtl/nibble_serial_sub_ctrl.sv
// ============================================================================
// Module  : nibble_serial_sub_ctrl
// Brief   : WIDTH-bit subtractor built from one time-shared 4-bit slice, LSB nibble first.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module nibble_serial_sub_ctrl
  import nibble_serial_sub_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input wire logic              clk,
  input wire logic              rst,
  nibble_serial_sub_ctrl_if.slave bus
);

  localparam int c_NIB   = WIDTH / 4;
  localparam int c_CNT_W = (c_NIB > 1) ? $clog2(c_NIB) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_NIB - 1);

  if (!nib_width_ok(WIDTH)) begin : g_width_err
    $error("nibble_serial_sub_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  state_t             r_state;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_res;
  logic [WIDTH-1:0]   r_d;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_borrow;
  logic               r_bout;
  logic               r_zero;
  logic               r_out_valid;

  logic [3:0]         w_nib_d;
  logic               w_nib_bo;
  logic [WIDTH-1:0]   w_res_next;

  nibble_borrow_sub u_slice (
    .i_a  (r_a_sh[3:0]),
    .i_b  (r_b_sh[3:0]),
    .i_bi (r_borrow),
    .o_d  (w_nib_d),
    .o_bo (w_nib_bo)
  );

  // New nibble enters at the MSB end so after NIB steps nibble 0 sits at the LSB.
  if (c_NIB == 1) begin : g_res_single
    assign w_res_next = w_nib_d;
  end else begin : g_res_shift
    assign w_res_next = {w_nib_d, r_res[WIDTH-1:4]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_res       <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      r_borrow    <= 1'b0;
      r_bout      <= 1'b0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_a_sh   <= bus.a;
            r_b_sh   <= bus.b;
            r_borrow <= bus.bin;
            r_cnt    <= '0;
            r_state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_a_sh   <= r_a_sh >> 4;
          r_b_sh   <= r_b_sh >> 4;
          r_res    <= w_res_next;
          r_borrow <= w_nib_bo;
          r_cnt    <= r_cnt + c_CNT_W'(1);
          if (r_cnt == c_CNT_LAST) begin
            r_d         <= w_res_next;
            r_bout      <= w_nib_bo;
            r_zero      <= (w_res_next == '0);
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.d         = r_d;
  assign bus.bout      = r_bout;
  assign bus.zero      = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_sub_ctrl.sv
// ============================================================================
// Module  : tb_nibble_serial_sub_ctrl
// Brief   : Directed and random checks of the nibble-serial subtractor at WIDTH=16 and WIDTH=4.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_nibble_serial_sub_ctrl;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_bad;

  nibble_serial_sub_ctrl_if #(.WIDTH(16)) bus16 ();
  nibble_serial_sub_ctrl_if #(.WIDTH(4))  bus4  ();

  nibble_serial_sub_ctrl #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));
  nibble_serial_sub_ctrl #(.WIDTH(4))  u_dut4  (.clk(clk), .rst(rst), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic bin,
                      input logic [15:0] exp_d, input logic exp_bo, input logic exp_z,
                      input string tag);
    int lat;
    bus16.a = a; bus16.b = b; bus16.bin = bin; bus16.in_valid = 1'b1;
    tick();
    bus16.in_valid = 1'b0;
    bus16.a = ~a; bus16.b = ~b; bus16.bin = ~bin;
    lat = 0;
    while (!bus16.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd4);
    check({tag, "_d"},   64'(bus16.d),    64'(exp_d));
    check({tag, "_bout"}, 64'(bus16.bout), 64'(exp_bo));
    check({tag, "_zero"}, 64'(bus16.zero), 64'(exp_z));
    bus16.out_ready = 1'b1;
    tick();
    bus16.out_ready = 1'b0;
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                     input logic [3:0] exp_d, input logic exp_bo, input string tag);
    int lat;
    bus4.a = a; bus4.b = b; bus4.bin = bin; bus4.in_valid = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    lat = 0;
    while (!bus4.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_lat"},  64'(lat),       64'd1);
    check({tag, "_d"},    64'(bus4.d),    64'(exp_d));
    check({tag, "_bout"}, 64'(bus4.bout), 64'(exp_bo));
    bus4.out_ready = 1'b1;
    tick();
    bus4.out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rbin;
    logic [16:0] rexp;
    logic [15:0] held_d;
    int          wait_cnt;

    n_chk = 0;
    n_bad = 0;
    rst = 1'b1;
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b0;
    bus16.a = '0; bus16.b = '0; bus16.bin = 1'b0;
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b0;
    bus4.a = '0; bus4.b = '0; bus4.bin = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_in_ready",  64'(bus16.in_ready),  64'd1);
    check("rst_out_valid", 64'(bus16.out_valid), 64'd0);
    check("rst_d",         64'(bus16.d),         64'd0);
    check("rst_bout",      64'(bus16.bout),      64'd0);
    check("rst_zero",      64'(bus16.zero),      64'd0);

    op16(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, "basic");
    op16(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, "underflow");
    op16(16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b0, "binmsb");
    op16(16'hBEEF, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 1'b1, "eqzero");
    op16(16'hBEEF, 16'hBEEF, 1'b1, 16'hFFFF, 1'b1, 1'b0, "eqbin");

    // Backpressure: result held in DONE while a competing operand is offered.
    bus16.a = 16'h5555; bus16.b = 16'h1111; bus16.bin = 1'b0; bus16.in_valid = 1'b1;
    tick();
    bus16.a = 16'hAAAA; bus16.b = 16'h0001; bus16.bin = 1'b1;
    wait_cnt = 0;
    while (!bus16.out_valid && wait_cnt < 20) begin
      tick();
      wait_cnt++;
    end
    check("bp_lat", 64'(wait_cnt), 64'd4);
    held_d = 16'h4444;
    for (int i = 0; i < 5; i++) begin
      check("bp_d",        64'(bus16.d),         64'(held_d));
      check("bp_in_ready", 64'(bus16.in_ready),  64'd0);
      check("bp_valid",    64'(bus16.out_valid), 64'd1);
      tick();
    end
    // in_valid still high while out_ready releases DONE: not accepted on this edge.
    bus16.out_ready = 1'b1;
    tick();
    bus16.out_ready = 1'b0;
    check("bp_rel_in_ready",  64'(bus16.in_ready),  64'd1);
    check("bp_rel_out_valid", 64'(bus16.out_valid), 64'd0);
    check("bp_rel_d_kept",    64'(bus16.d),         64'(held_d));
    tick();
    bus16.in_valid = 1'b0;
    check("bp_next_accept", 64'(bus16.in_ready), 64'd0);
    wait_cnt = 0;
    while (!bus16.out_valid && wait_cnt < 20) begin
      tick();
      wait_cnt++;
    end
    check("bp2_d",    64'(bus16.d),    64'h0000_0000_0000_AAA8);
    check("bp2_bout", 64'(bus16.bout), 64'd0);
    bus16.out_ready = 1'b1;
    tick();
    bus16.out_ready = 1'b0;

    // Reset mid-RUN drops the operation.
    bus16.a = 16'h1111; bus16.b = 16'h2222; bus16.bin = 1'b0; bus16.in_valid = 1'b1;
    tick();
    bus16.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready",  64'(bus16.in_ready),  64'd1);
    check("midrst_out_valid", 64'(bus16.out_valid), 64'd0);
    check("midrst_d",         64'(bus16.d),         64'd0);
    op16(16'h00FF, 16'h0001, 1'b1, 16'h00FD, 1'b0, 1'b0, "postrst");

    op4(4'h3, 4'h5, 1'b0, 4'hE, 1'b1, "w4_neg");
    op4(4'h7, 4'h2, 1'b1, 4'h4, 1'b0, "w4_pos");
    op4(4'h0, 4'h0, 1'b1, 4'hF, 1'b1, "w4_bin");

    for (int i = 0; i < 300; i++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom);
      rexp = {1'b0, ra} - {1'b0, rb} - 17'(rbin);
      op16(ra, rb, rbin, rexp[15:0], rexp[16], (rexp[15:0] == 16'h0), "rand");
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
